// File: rtl/msk_rx_pkg.sv
// Shared types and default tuning constants for the MSK receive acquisition sequencer.
package msk_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CFO    = 3'd2,
    ST_APPLY  = 3'd3,
    ST_VERIFY = 3'd4,
    ST_TRACK  = 3'd5,
    ST_RETRY  = 3'd6,
    ST_FAIL   = 3'd7
  } acq_state_t;

  localparam int WERR_DEF         = 18;
  localparam int FW_DEF           = 32;
  localparam int SETTLE_SYMS_DEF  = 256;
  localparam int CFO_TIMEOUT_DEF  = 4096;
  localparam int WIN_LOG2_DEF     = 6;
  localparam int LOCK_THR_DEF     = 1 << 20;
  localparam int UNLOCK_THR_DEF   = 1 << 22;
  localparam int LOSS_WINDOWS_DEF = 3;
  localparam int MAX_RETRY_DEF    = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/msk_rx_acq_ctrl_lock_det.sv
// Windowed |TED error| accumulator: sums 2**WIN_LOG2 clamped magnitudes, then reports and restarts.
module msk_lock_det
  import msk_rx_pkg::*;
#(
  parameter int WERR     = WERR_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [WERR-1:0]          ek,
  input  logic                     ek_val,
  output logic [WERR+WIN_LOG2-1:0] sum,
  output logic                     win_done
);

  localparam int SW = WERR + WIN_LOG2;

  logic [WERR-1:0]     abs_val;
  logic [SW-1:0]       acc;
  logic [SW-1:0]       acc_next;
  logic [WIN_LOG2-1:0] cnt;

  // The most negative code has no positive twin, so it is clamped to the largest positive value.
  always_comb begin
    abs_val = ek;
    if (ek == {1'b1, {(WERR-1){1'b0}}})
      abs_val = {1'b0, {(WERR-1){1'b1}}};
    else if (ek[WERR-1])
      abs_val = '0 - ek;
    acc_next = acc + {{WIN_LOG2{1'b0}}, abs_val};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      sum      <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (ek_val) begin
        if (cnt == '1) begin
          sum      <= acc_next;
          win_done <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/msk_rx_acq_ctrl.sv
// MSK receive acquisition/tracking sequencer: timing settle, coarse CFO load, lock qualification, retry.
module msk_rx_acq_ctrl
  import msk_rx_pkg::*;
#(
  parameter int WERR         = WERR_DEF,
  parameter int FW           = FW_DEF,
  parameter int SETTLE_SYMS  = SETTLE_SYMS_DEF,
  parameter int CFO_TIMEOUT  = CFO_TIMEOUT_DEF,
  parameter int WIN_LOG2     = WIN_LOG2_DEF,
  parameter int LOCK_THR     = LOCK_THR_DEF,
  parameter int UNLOCK_THR   = UNLOCK_THR_DEF,
  parameter int LOSS_WINDOWS = LOSS_WINDOWS_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            restart_i,
  input  logic            sym_val_i,
  input  logic [WERR-1:0] ek_i,
  input  logic            ek_val_i,
  input  logic            cfo_done_i,
  input  logic [FW-1:0]   cfo_freq_i,
  output logic            timing_en_o,
  output logic            cfo_en_o,
  output logic [FW-1:0]   freq_word_o,
  output logic            freq_word_val_o,
  output logic            locked_o,
  output logic            fail_o,
  output logic [2:0]      state_o,
  output logic [2:0]      retry_cnt_o
);

  localparam int SW = WERR + WIN_LOG2;
  localparam int CW = $clog2(max_int(SETTLE_SYMS, CFO_TIMEOUT) + 1);
  localparam int LW = $clog2(LOSS_WINDOWS + 1);

  acq_state_t     state;
  acq_state_t     state_next;
  logic [CW-1:0]  sym_cnt;
  logic [LW-1:0]  loss_cnt;
  logic [2:0]     retry_cnt;
  logic [SW-1:0]  win_sum;
  logic           win_done;
  logic           abort;
  logic           settle_done;
  logic           cfo_timeout;
  logic           win_bad;
  logic           loss_trip;
  logic           det_clr;
  logic           det_val;

  assign abort       = !en_i || restart_i;
  assign settle_done = sym_val_i && (sym_cnt == CW'(SETTLE_SYMS - 1));
  assign cfo_timeout = sym_val_i && (sym_cnt == CW'(CFO_TIMEOUT - 1));
  assign win_bad     = win_sum > SW'(UNLOCK_THR);
  assign loss_trip   = win_done && win_bad && (loss_cnt == LW'(LOSS_WINDOWS - 1));
  assign det_clr     = (state_next != state) && (state_next == ST_VERIFY || state_next == ST_TRACK);
  assign det_val     = ek_val_i && (state == ST_VERIFY || state == ST_TRACK);
  assign state_o     = state;
  assign retry_cnt_o = retry_cnt;

  msk_lock_det #(.WERR(WERR), .WIN_LOG2(WIN_LOG2)) u_lock_det (
    .clk      (clk),
    .rst      (rst),
    .clr      (det_clr),
    .ek       (ek_i),
    .ek_val   (det_val),
    .sum      (win_sum),
    .win_done (win_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // A CFO estimate arriving on the timeout symbol still counts as a success.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_next = ST_SETTLE;
        ST_SETTLE: if (settle_done) state_next = ST_CFO;
        ST_CFO: begin
          if (cfo_done_i)       state_next = ST_APPLY;
          else if (cfo_timeout) state_next = ST_RETRY;
        end
        ST_APPLY:  state_next = ST_VERIFY;
        ST_VERIFY: if (win_done) state_next = (win_sum <= SW'(LOCK_THR)) ? ST_TRACK : ST_RETRY;
        ST_TRACK:  if (loss_trip) state_next = ST_RETRY;
        ST_RETRY:  state_next = (retry_cnt == 3'(MAX_RETRY)) ? ST_FAIL : ST_SETTLE;
        ST_FAIL:   state_next = ST_FAIL;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt   <= '0;
      loss_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      if (state_next != state)
        sym_cnt <= '0;
      else if (sym_val_i && (state == ST_SETTLE || state == ST_CFO) && sym_cnt != '1)
        sym_cnt <= sym_cnt + 1'b1;

      if (state != ST_TRACK)
        loss_cnt <= '0;
      else if (win_done)
        loss_cnt <= win_bad ? ((loss_cnt != '1) ? loss_cnt + 1'b1 : loss_cnt) : '0;

      if (state_next == ST_IDLE)
        retry_cnt <= '0;
      else if (state_next == ST_RETRY && state != ST_RETRY && retry_cnt != 3'd7)
        retry_cnt <= retry_cnt + 1'b1;
    end
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timing_en_o     <= 1'b0;
      cfo_en_o        <= 1'b0;
      locked_o        <= 1'b0;
      fail_o          <= 1'b0;
      freq_word_o     <= '0;
      freq_word_val_o <= 1'b0;
    end else begin
      timing_en_o     <= (state_next == ST_SETTLE) || (state_next == ST_CFO) ||
                         (state_next == ST_APPLY)  || (state_next == ST_VERIFY) ||
                         (state_next == ST_TRACK);
      cfo_en_o        <= (state_next == ST_CFO);
      locked_o        <= (state_next == ST_TRACK);
      fail_o          <= (state_next == ST_FAIL);
      freq_word_val_o <= 1'b0;
      if (state_next == ST_APPLY && state != ST_APPLY) begin
        freq_word_o     <= cfo_freq_i;
        freq_word_val_o <= 1'b1;
      end else if (state_next == ST_RETRY) begin
        freq_word_o     <= '0;
        freq_word_val_o <= 1'b1;
      end else if (state_next == ST_IDLE && freq_word_o != '0) begin
        freq_word_o     <= '0;
        freq_word_val_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_msk_rx_acq_ctrl.sv
// Directed self-checking bench for msk_rx_acq_ctrl with default parameters.
module tb_msk_rx_acq_ctrl;
  import msk_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i, restart_i, sym_val_i, ek_val_i, cfo_done_i;
  logic [17:0] ek_i;
  logic [31:0] cfo_freq_i;
  logic        timing_en_o, cfo_en_o, freq_word_val_o, locked_o, fail_o;
  logic [31:0] freq_word_o;
  logic [2:0]  state_o, retry_cnt_o;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  msk_rx_acq_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .en_i            (en_i),
    .restart_i       (restart_i),
    .sym_val_i       (sym_val_i),
    .ek_i            (ek_i),
    .ek_val_i        (ek_val_i),
    .cfo_done_i      (cfo_done_i),
    .cfo_freq_i      (cfo_freq_i),
    .timing_en_o     (timing_en_o),
    .cfo_en_o        (cfo_en_o),
    .freq_word_o     (freq_word_o),
    .freq_word_val_o (freq_word_val_o),
    .locked_o        (locked_o),
    .fail_o          (fail_o),
    .state_o         (state_o),
    .retry_cnt_o     (retry_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses sym_val_i for one clock per symbol, one symbol every 'period' clocks.
  task automatic applyStimulus(input int syms, input int period);
    for (int i = 0; i < syms; i++) begin
      sym_val_i = 1'b1;
      tick();
      sym_val_i = 1'b0;
      repeat (period - 1) tick();
    end
  endtask

  // One full lock window of 64 error samples, then one idle clock for the verdict to land.
  task automatic feed_window(input logic [17:0] mag, input bit alt);
    for (int i = 0; i < 64; i++) begin
      ek_i     = (alt && i[0]) ? (18'd0 - mag) : mag;
      ek_val_i = 1'b1;
      tick();
    end
    ek_val_i = 1'b0;
    ek_i     = '0;
    tick();
  endtask

  task automatic run_until_state(input acq_state_t target, input int max_syms, input string tag);
    int n;
    n = 0;
    while (state_o != target && n < max_syms) begin
      applyStimulus(1, 1);
      n++;
    end
    checkOutput(tag, 64'(state_o), 64'(target));
  endtask

  // From SETTLE: settle, estimate after cfo_syms symbols, apply, and land in VERIFY.
  task automatic acquire(input logic [31:0] freq, input int cfo_syms, input string tag);
    applyStimulus(256, 1);
    checkOutput({tag, "_cfo"}, 64'(state_o), 64'(ST_CFO));
    applyStimulus(cfo_syms, 1);
    cfo_freq_i = freq;
    cfo_done_i = 1'b1;
    tick();
    cfo_done_i = 1'b0;
    checkOutput({tag, "_apply"}, 64'(state_o), 64'(ST_APPLY));
    checkOutput({tag, "_freq"}, 64'(freq_word_o), 64'(freq));
    checkOutput({tag, "_fval"}, 64'(freq_word_val_o), 64'd1);
    tick();
    checkOutput({tag, "_verify"}, 64'(state_o), 64'(ST_VERIFY));
  endtask

  initial begin
    rst        = 1'b1;
    en_i       = 1'b0;
    restart_i  = 1'b0;
    sym_val_i  = 1'b0;
    ek_i       = '0;
    ek_val_i   = 1'b0;
    cfo_done_i = 1'b0;
    cfo_freq_i = '0;
    repeat (3) tick();
    checkOutput("rst_state", 64'(state_o), 64'(ST_IDLE));
    checkOutput("rst_outs", 64'({timing_en_o, cfo_en_o, freq_word_val_o, locked_o, fail_o}), 64'd0);
    checkOutput("rst_freq", 64'(freq_word_o), 64'd0);
    checkOutput("rst_retry", 64'(retry_cnt_o), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_hold", 64'(state_o), 64'(ST_IDLE));

    // Nominal acquisition with a symbol every 20 clocks.
    en_i = 1'b1;
    tick();
    checkOutput("t1_settle", 64'(state_o), 64'(ST_SETTLE));
    checkOutput("t1_timing_en", 64'(timing_en_o), 64'd1);
    applyStimulus(255, 20);
    checkOutput("t1_settle_255", 64'(state_o), 64'(ST_SETTLE));
    applyStimulus(1, 20);
    checkOutput("t1_cfo_256", 64'(state_o), 64'(ST_CFO));
    checkOutput("t1_cfo_en", 64'(cfo_en_o), 64'd1);
    applyStimulus(100, 20);
    checkOutput("t1_cfo_wait", 64'(state_o), 64'(ST_CFO));
    cfo_freq_i = 32'h0123_4567;
    cfo_done_i = 1'b1;
    tick();
    cfo_done_i = 1'b0;
    checkOutput("t1_apply", 64'(state_o), 64'(ST_APPLY));
    checkOutput("t1_freq", 64'(freq_word_o), 64'h0123_4567);
    checkOutput("t1_fval", 64'(freq_word_val_o), 64'd1);
    checkOutput("t1_cfo_en_off", 64'(cfo_en_o), 64'd0);
    tick();
    checkOutput("t1_verify", 64'(state_o), 64'(ST_VERIFY));
    checkOutput("t1_fval_low", 64'(freq_word_val_o), 64'd0);
    feed_window(18'd0, 1'b0);
    checkOutput("t1_track", 64'(state_o), 64'(ST_TRACK));
    checkOutput("t1_locked", 64'(locked_o), 64'd1);

    // Window sum 64*100000 = 6400000 exceeds the unlock threshold; 0 is a good window.
    feed_window(18'd100000, 1'b1);
    feed_window(18'd100000, 1'b1);
    feed_window(18'd0, 1'b0);
    checkOutput("t3_hold_state", 64'(state_o), 64'(ST_TRACK));
    checkOutput("t3_hold_locked", 64'(locked_o), 64'd1);
    feed_window(18'd100000, 1'b1);
    feed_window(18'd100000, 1'b1);
    checkOutput("t3_two_bad", 64'(state_o), 64'(ST_TRACK));
    feed_window(18'd100000, 1'b1);
    checkOutput("t3_retry", 64'(state_o), 64'(ST_RETRY));
    checkOutput("t3_unlocked", 64'(locked_o), 64'd0);
    checkOutput("t3_freq_zero", 64'(freq_word_o), 64'd0);
    checkOutput("t3_fval", 64'(freq_word_val_o), 64'd1);
    checkOutput("t3_retry_cnt", 64'(retry_cnt_o), 64'd1);
    checkOutput("t3_timing_off", 64'(timing_en_o), 64'd0);
    tick();
    checkOutput("t3_resettle", 64'(state_o), 64'(ST_SETTLE));

    // Estimate arrives on the very symbol that would time out.
    applyStimulus(256, 1);
    checkOutput("t5_cfo", 64'(state_o), 64'(ST_CFO));
    applyStimulus(4095, 1);
    checkOutput("t5_cfo_4095", 64'(state_o), 64'(ST_CFO));
    sym_val_i  = 1'b1;
    cfo_done_i = 1'b1;
    cfo_freq_i = 32'h0000_ABCD;
    tick();
    sym_val_i  = 1'b0;
    cfo_done_i = 1'b0;
    checkOutput("t5_apply", 64'(state_o), 64'(ST_APPLY));
    checkOutput("t5_freq", 64'(freq_word_o), 64'h0000_ABCD);
    checkOutput("t5_retry_cnt", 64'(retry_cnt_o), 64'd1);
    tick();
    checkOutput("t5_verify", 64'(state_o), 64'(ST_VERIFY));

    // Most negative error clamps to 131071; 64*131071 = 8388544 fails the lock test.
    feed_window(18'h20000, 1'b0);
    checkOutput("t4_retry", 64'(state_o), 64'(ST_RETRY));
    checkOutput("t4_retry_cnt", 64'(retry_cnt_o), 64'd2);
    checkOutput("t4_freq_zero", 64'(freq_word_o), 64'd0);
    tick();
    checkOutput("t4_resettle", 64'(state_o), 64'(ST_SETTLE));

    // Abort out of TRACK with a nonzero word.
    acquire(32'h7FFF_0001, 5, "t6a");
    feed_window(18'd1000, 1'b1);
    checkOutput("t6a_track", 64'(state_o), 64'(ST_TRACK));
    en_i = 1'b0;
    tick();
    checkOutput("t6a_idle", 64'(state_o), 64'(ST_IDLE));
    checkOutput("t6a_freq", 64'(freq_word_o), 64'd0);
    checkOutput("t6a_fval", 64'(freq_word_val_o), 64'd1);
    checkOutput("t6a_outs", 64'({timing_en_o, cfo_en_o, locked_o, fail_o}), 64'd0);
    checkOutput("t6a_retry_clr", 64'(retry_cnt_o), 64'd0);
    tick();
    checkOutput("t6a_fval_low", 64'(freq_word_val_o), 64'd0);

    // Asynchronous reset in the middle of TRACK.
    en_i = 1'b1;
    tick();
    checkOutput("t6b_settle", 64'(state_o), 64'(ST_SETTLE));
    acquire(32'h0000_0042, 3, "t6b");
    feed_window(18'd0, 1'b0);
    checkOutput("t6b_track", 64'(state_o), 64'(ST_TRACK));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("t6b_rst_state", 64'(state_o), 64'(ST_IDLE));
    checkOutput("t6b_rst_outs", 64'({timing_en_o, cfo_en_o, freq_word_val_o, locked_o, fail_o}), 64'd0);
    checkOutput("t6b_rst_freq", 64'(freq_word_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("t6b_restart", 64'(state_o), 64'(ST_SETTLE));

    // en_i dropped while the CFO estimator runs; word is already zero so no pulse.
    applyStimulus(256, 1);
    checkOutput("t6c_cfo", 64'(state_o), 64'(ST_CFO));
    applyStimulus(50, 1);
    en_i = 1'b0;
    tick();
    checkOutput("t6c_idle", 64'(state_o), 64'(ST_IDLE));
    checkOutput("t6c_outs", 64'({timing_en_o, cfo_en_o, freq_word_val_o, locked_o}), 64'd0);
    checkOutput("t6c_freq", 64'(freq_word_o), 64'd0);

    // Repeated CFO timeouts until retries are exhausted.
    en_i = 1'b1;
    tick();
    checkOutput("t2_settle", 64'(state_o), 64'(ST_SETTLE));
    for (int r = 1; r <= 7; r++) begin
      run_until_state(ST_RETRY, 5000, "t2_reach_retry");
      checkOutput("t2_retry_cnt", 64'(retry_cnt_o), 64'(r));
      checkOutput("t2_fval", 64'(freq_word_val_o), 64'd1);
      tick();
      checkOutput("t2_after_retry", 64'(state_o), (r == 7) ? 64'(ST_FAIL) : 64'(ST_SETTLE));
    end
    checkOutput("t2_fail", 64'(fail_o), 64'd1);
    checkOutput("t2_fail_timing", 64'(timing_en_o), 64'd0);
    repeat (5) tick();
    checkOutput("t2_fail_held", 64'(state_o), 64'(ST_FAIL));
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    checkOutput("t2_restart_idle", 64'(state_o), 64'(ST_IDLE));
    checkOutput("t2_restart_fail", 64'(fail_o), 64'd0);
    checkOutput("t2_restart_retry", 64'(retry_cnt_o), 64'd0);
    tick();
    checkOutput("t2_restart_settle", 64'(state_o), 64'(ST_SETTLE));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
